// File: rtl/psg_bus_sequencer.sv
// psg_bus_sequencer: owns the BDIR/BC/DI bus of a dual-AY TurboSound block.
// Arbitrates CPU port strobes against a loader engine writing (chip,reg,value)
// tuples, then restores the CPU-visible chip selection and latched register.
//
// Parameter:
//   HOLD_CYCLES   cycles each bus phase is driven (1..15); a 1-cycle gap follows
// Configuration macro:
//   PSG_SEQ_SHADOW_EN  skip loader select/restore phases that match the shadows
// Ports:
//   CLK, RESET_N                    clock, synchronous active-low reset
//   CPU_ADDR_WR/DATA_WR/RD, CPU_DI  CPU strobes and write data
//   CPU_DO, CPU_DO_VALID, CPU_WAIT  read data, read pulse, request buffer busy
//   LD_VALID/READY, LD_CHIP/REG/VAL loader tuple handshake and payload
//   PSG_BDIR, PSG_BC, PSG_DI, PSG_DO TurboSound bus
//   CPU_SEL, BUSY                   CPU chip shadow, sequencer active
module psg_bus_sequencer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CPU_ADDR_WR,
    input  logic       CPU_DATA_WR,
    input  logic       CPU_RD,
    input  logic [7:0] CPU_DI,
    output logic [7:0] CPU_DO,
    output logic       CPU_DO_VALID,
    output logic       CPU_WAIT,
    input  logic       LD_VALID,
    output logic       LD_READY,
    input  logic       LD_CHIP,
    input  logic [3:0] LD_REG,
    input  logic [7:0] LD_VAL,
    output logic       PSG_BDIR,
    output logic       PSG_BC,
    output logic [7:0] PSG_DI,
    input  logic [7:0] PSG_DO,
    output logic       CPU_SEL,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE, CPU_OP, L_SEL, L_ADDR, L_DATA, R_ADDR, R_SEL, GAP
    } state_t;

    typedef enum logic [1:0] {OP_ADDR, OP_DATA, OP_RD} op_t;

    localparam logic [3:0] LAST = 4'(HOLD_CYCLES - 1);

    state_t          state;
    state_t          after_gap;
    logic [3:0]      cnt;
    logic            buf_valid;
    op_t             buf_op;
    logic [7:0]      buf_data;
    op_t             cur_op;
    logic            t_chip;
    logic [3:0]      t_reg;
    logic [7:0]      t_val;
    logic            cpu_sel;
    logic [1:0][3:0] cpu_addr;
    logic            ready_q;
    logic            bdir_q;
    logic            bc_q;
    logic [7:0]      di_q;
    logic [7:0]      do_q;
    logic            do_valid_q;

    logic            start_skip;
    logic            skip_sel;
    logic            skip_addr;
    state_t          ld_first;
    state_t          phase_next;
    logic [8:0]      ld_first_bus;
    logic [8:0]      gap_bus;

`ifdef PSG_SEQ_SHADOW_EN
    assign start_skip = (LD_CHIP == cpu_sel);
    assign skip_sel   = (t_chip == cpu_sel);
    assign skip_addr  = (t_reg == cpu_addr[t_chip]);
`else
    assign start_skip = 1'b0;
    assign skip_sel   = 1'b0;
    assign skip_addr  = 1'b0;
`endif

    // Loader phase order; select/restore phases drop out when skipped.
    function automatic state_t next_phase(state_t cur, logic ss, logic sa);
        state_t n;
        n = IDLE;
        case (cur)
            L_SEL:   n = L_ADDR;
            L_ADDR:  n = L_DATA;
            L_DATA:  n = sa ? (ss ? IDLE : R_SEL) : R_ADDR;
            R_ADDR:  n = ss ? IDLE : R_SEL;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // {BC, DI} driven during a loader phase.
    function automatic logic [8:0] phase_bus(
        state_t ph, logic chip, logic [3:0] rg, logic [7:0] val,
        logic sel, logic [3:0] raddr
    );
        logic [8:0] b;
        b = {1'b1, 7'h7F, sel};
        case (ph)
            L_SEL:   b = {1'b1, 7'h7F, chip};
            L_ADDR:  b = {1'b1, 4'h0, rg};
            L_DATA:  b = {1'b0, val};
            R_ADDR:  b = {1'b1, 4'h0, raddr};
            default: b = {1'b1, 7'h7F, sel};
        endcase
        return b;
    endfunction

    assign ld_first     = start_skip ? L_ADDR : L_SEL;
    assign phase_next   = next_phase(state, skip_sel, skip_addr);
    assign ld_first_bus = phase_bus(ld_first, LD_CHIP, LD_REG, LD_VAL,
                                    cpu_sel, cpu_addr[LD_CHIP]);
    assign gap_bus      = phase_bus(after_gap, t_chip, t_reg, t_val,
                                    cpu_sel, cpu_addr[t_chip]);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= IDLE;
            after_gap  <= IDLE;
            cnt        <= '0;
            buf_valid  <= 1'b0;
            buf_op     <= OP_ADDR;
            buf_data   <= '0;
            cur_op     <= OP_ADDR;
            t_chip     <= 1'b0;
            t_reg      <= '0;
            t_val      <= '0;
            cpu_sel    <= 1'b1;
            cpu_addr   <= '0;
            ready_q    <= 1'b0;
            bdir_q     <= 1'b0;
            bc_q       <= 1'b0;
            di_q       <= '0;
            do_q       <= '0;
            do_valid_q <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            do_valid_q <= 1'b0;

            if (!buf_valid && (CPU_ADDR_WR || CPU_DATA_WR || CPU_RD)) begin
                buf_valid <= 1'b1;
                buf_data  <= CPU_DI;
                buf_op    <= CPU_ADDR_WR ? OP_ADDR :
                             (CPU_DATA_WR ? OP_DATA : OP_RD);
            end

            case (state)
                IDLE: begin
                    if (buf_valid) begin
                        buf_valid <= 1'b0;
                        cur_op    <= buf_op;
                        cnt       <= '0;
                        state     <= CPU_OP;
                        case (buf_op)
                            OP_ADDR: begin
                                bdir_q <= 1'b1;
                                bc_q   <= 1'b1;
                                di_q   <= buf_data;
                                // 0xFE/0xFF are the TurboSound chip-select codes
                                if (buf_data[7:1] == 7'h7F)
                                    cpu_sel <= buf_data[0];
                                else
                                    cpu_addr[cpu_sel] <= buf_data[3:0];
                            end
                            OP_DATA: begin
                                bdir_q <= 1'b1;
                                bc_q   <= 1'b0;
                                di_q   <= buf_data;
                            end
                            default: begin
                                bdir_q <= 1'b0;
                                bc_q   <= 1'b1;
                            end
                        endcase
                    end else if (LD_VALID && LD_READY) begin
                        t_chip        <= LD_CHIP;
                        t_reg         <= LD_REG;
                        t_val         <= LD_VAL;
                        cnt           <= '0;
                        state         <= ld_first;
                        bdir_q        <= 1'b1;
                        {bc_q, di_q}  <= ld_first_bus;
                    end
                end
                CPU_OP, L_SEL, L_ADDR, L_DATA, R_ADDR, R_SEL: begin
                    if (cnt == LAST) begin
                        state     <= GAP;
                        bdir_q    <= 1'b0;
                        bc_q      <= 1'b0;
                        after_gap <= (state == CPU_OP) ? IDLE : phase_next;
                        if (state == CPU_OP && cur_op == OP_RD) begin
                            do_q       <= PSG_DO;
                            do_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (after_gap == IDLE) begin
                        state <= IDLE;
                    end else begin
                        state        <= after_gap;
                        cnt          <= '0;
                        bdir_q       <= 1'b1;
                        {bc_q, di_q} <= gap_bus;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign PSG_BDIR     = bdir_q;
    assign PSG_BC       = bc_q;
    assign PSG_DI       = di_q;
    assign CPU_DO       = do_q;
    assign CPU_DO_VALID = do_valid_q;
    assign CPU_WAIT     = buf_valid;
    assign CPU_SEL      = cpu_sel;
    assign BUSY         = (state != IDLE);
    assign LD_READY     = ready_q && (state == IDLE) && !buf_valid;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// tb_psg_bus_sequencer: table-driven vectors plus hand-written sequences;
// bus phases and read data are checked against a scoreboard queue.
module tb_psg_bus_sequencer;

    localparam int HOLD = 2;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       CPU_ADDR_WR = 1'b0;
    logic       CPU_DATA_WR = 1'b0;
    logic       CPU_RD = 1'b0;
    logic [7:0] CPU_DI = '0;
    logic [7:0] CPU_DO;
    logic       CPU_DO_VALID;
    logic       CPU_WAIT;
    logic       LD_VALID = 1'b0;
    logic       LD_READY;
    logic       LD_CHIP = 1'b0;
    logic [3:0] LD_REG = '0;
    logic [7:0] LD_VAL = '0;
    logic       PSG_BDIR;
    logic       PSG_BC;
    logic [7:0] PSG_DI;
    logic [7:0] PSG_DO = '0;
    logic       CPU_SEL;
    logic       BUSY;

    psg_bus_sequencer #(.HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CPU_ADDR_WR(CPU_ADDR_WR), .CPU_DATA_WR(CPU_DATA_WR),
        .CPU_RD(CPU_RD), .CPU_DI(CPU_DI), .CPU_DO(CPU_DO),
        .CPU_DO_VALID(CPU_DO_VALID), .CPU_WAIT(CPU_WAIT),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_CHIP(LD_CHIP),
        .LD_REG(LD_REG), .LD_VAL(LD_VAL), .PSG_BDIR(PSG_BDIR),
        .PSG_BC(PSG_BC), .PSG_DI(PSG_DI), .PSG_DO(PSG_DO),
        .CPU_SEL(CPU_SEL), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic            is_ld;
        logic [2:0]      strb;
        logic [7:0]      di;
        logic            chip;
        logic [3:0]      rg;
        logic [7:0]      val;
        int              nph;
        logic [4:0][9:0] ph;
        int              cyc;
        logic            sel;
    } vec_t;

    int          pass_cnt = 0;
    int          tot_cnt = 0;
    logic [9:0]  ph_q[$];
    logic [7:0]  rd_q[$];
    bit          mon_en = 1'b0;
    logic        prev_act = 1'b0;
    logic        prev_v = 1'b0;
    int          run_len = 0;
    vec_t        vt[13];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(string nm);
        tot_cnt++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [9:0] pw(logic bc, logic [7:0] d);
        return {1'b1, bc, d};
    endfunction

    function automatic vec_t mk(
        logic is_ld, logic [2:0] strb, logic [7:0] di, logic chip,
        logic [3:0] rg, logic [7:0] val, int n,
        logic [9:0] p0, logic [9:0] p1, logic [9:0] p2,
        logic [9:0] p3, logic [9:0] p4, logic sel
    );
        vec_t v;
        v.is_ld = is_ld;
        v.strb  = strb;
        v.di    = di;
        v.chip  = chip;
        v.rg    = rg;
        v.val   = val;
        v.nph   = n;
        v.ph[0] = p0;
        v.ph[1] = p1;
        v.ph[2] = p2;
        v.ph[3] = p3;
        v.ph[4] = p4;
        v.cyc   = n * (HOLD + 1);
        v.sel   = sel;
        return v;
    endfunction

    // Bus-phase and read-data monitor
    always @(negedge CLK) begin
        if (mon_en) begin
            if (PSG_BDIR || PSG_BC) begin
                if (!prev_act) begin
                    if (ph_q.size() == 0)
                        fail("unexpected_phase");
                    else
                        chk("phase", {22'b0, PSG_BDIR, PSG_BC, PSG_DI},
                            {22'b0, ph_q.pop_front()});
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end else if (prev_act) begin
                chk("hold_len", run_len, HOLD);
            end
            if (CPU_DO_VALID) begin
                if (prev_v) fail("do_valid_width");
                if (rd_q.size() == 0) fail("unexpected_read");
                else chk("cpu_do", {24'b0, CPU_DO}, {24'b0, rd_q.pop_front()});
            end
        end
        prev_act = PSG_BDIR || PSG_BC;
        prev_v   = CPU_DO_VALID;
    end

    task automatic run_vec(vec_t v, string nm);
        int  cnt;
        bit  seen;
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < v.nph; k++) ph_q.push_back(v.ph[k]);
        if (!v.is_ld && v.strb == 3'b001) rd_q.push_back(v.val);
        @(negedge CLK);
        if (v.is_ld) begin
            chk({nm, "_ld_ready"}, LD_READY, 1);
            LD_CHIP  = v.chip;
            LD_REG   = v.rg;
            LD_VAL   = v.val;
            LD_VALID = 1'b1;
        end else begin
            CPU_ADDR_WR = v.strb[2];
            CPU_DATA_WR = v.strb[1];
            CPU_RD      = v.strb[0];
            CPU_DI      = v.di;
            PSG_DO      = v.val;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            LD_VALID    = 1'b0;
            CPU_ADDR_WR = 1'b0;
            CPU_DATA_WR = 1'b0;
            CPU_RD      = 1'b0;
            if (BUSY) begin
                seen = 1'b1;
                cnt++;
            end else if (seen) begin
                break;
            end
        end
        chk({nm, "_busy_cycles"}, cnt, v.cyc);
        chk({nm, "_cpu_sel"}, CPU_SEL, v.sel);
    endtask

    initial begin
        int  wcnt;
        bit  hit;

        // v0: sel=1, addr0=0 restore path
        vt[0]  = mk(1, 0, 0, 0, 4'h8, 8'h0F, 5, pw(1, 8'hFE), pw(1, 8'h08),
                    pw(0, 8'h0F), pw(1, 8'h00), pw(1, 8'hFF), 1);
        vt[1]  = mk(0, 3'b100, 8'h07, 0, 0, 0, 1, pw(1, 8'h07), 0, 0, 0, 0, 1);
`ifdef PSG_SEQ_SHADOW_EN
        vt[2]  = mk(1, 0, 0, 1, 4'h5, 8'hAA, 3, pw(1, 8'h05), pw(0, 8'hAA),
                    pw(1, 8'h07), 0, 0, 1);
`else
        vt[2]  = mk(1, 0, 0, 1, 4'h5, 8'hAA, 5, pw(1, 8'hFF), pw(1, 8'h05),
                    pw(0, 8'hAA), pw(1, 8'h07), pw(1, 8'hFF), 1);
`endif
        vt[3]  = mk(0, 3'b010, 8'h55, 0, 0, 0, 1, pw(0, 8'h55), 0, 0, 0, 0, 1);
        vt[4]  = mk(0, 3'b111, 8'hFE, 0, 0, 0, 1, pw(1, 8'hFE), 0, 0, 0, 0, 0);
        vt[5]  = mk(0, 3'b011, 8'h03, 0, 0, 0, 1, pw(0, 8'h03), 0, 0, 0, 0, 0);
        vt[6]  = mk(0, 3'b100, 8'h03, 0, 0, 0, 1, pw(1, 8'h03), 0, 0, 0, 0, 0);
`ifdef PSG_SEQ_SHADOW_EN
        vt[7]  = mk(1, 0, 0, 0, 4'h3, 8'h99, 2, pw(1, 8'h03), pw(0, 8'h99),
                    0, 0, 0, 0);
`else
        vt[7]  = mk(1, 0, 0, 0, 4'h3, 8'h99, 5, pw(1, 8'hFE), pw(1, 8'h03),
                    pw(0, 8'h99), pw(1, 8'h03), pw(1, 8'hFE), 0);
`endif
        vt[8]  = mk(1, 0, 0, 1, 4'h2, 8'h11, 5, pw(1, 8'hFF), pw(1, 8'h02),
                    pw(0, 8'h11), pw(1, 8'h07), pw(1, 8'hFE), 0);
        vt[9]  = mk(0, 3'b001, 8'h00, 0, 0, 8'h3C, 1, {2'b01, 8'hFE},
                    0, 0, 0, 0, 0);
        vt[10] = mk(0, 3'b100, 8'hFF, 0, 0, 0, 1, pw(1, 8'hFF), 0, 0, 0, 0, 1);
`ifdef PSG_SEQ_SHADOW_EN
        vt[11] = mk(1, 0, 0, 0, 4'h3, 8'h42, 4, pw(1, 8'hFE), pw(1, 8'h03),
                    pw(0, 8'h42), pw(1, 8'hFF), 0, 1);
        vt[12] = mk(1, 0, 0, 1, 4'h7, 8'h3C, 2, pw(1, 8'h07), pw(0, 8'h3C),
                    0, 0, 0, 1);
`else
        vt[11] = mk(1, 0, 0, 0, 4'h3, 8'h42, 5, pw(1, 8'hFE), pw(1, 8'h03),
                    pw(0, 8'h42), pw(1, 8'h03), pw(1, 8'hFF), 1);
        vt[12] = mk(1, 0, 0, 1, 4'h7, 8'h3C, 5, pw(1, 8'hFF), pw(1, 8'h07),
                    pw(0, 8'h3C), pw(1, 8'h07), pw(1, 8'hFF), 1);
`endif

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_bdir", PSG_BDIR, 0);
        chk("rst_bc", PSG_BC, 0);
        chk("rst_di", PSG_DI, 0);
        chk("rst_cpu_sel", CPU_SEL, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_ld_ready", LD_READY, 0);
        chk("rst_wait", CPU_WAIT, 0);
        chk("rst_do", CPU_DO, 0);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rel_ld_ready", LD_READY, 1);
        mon_en = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // CPU read queued behind a loader tuple
        ph_q.push_back(pw(1, 8'hFE));
        ph_q.push_back(pw(1, 8'h08));
        ph_q.push_back(pw(0, 8'h0F));
        ph_q.push_back(pw(1, 8'h03));
        ph_q.push_back(pw(1, 8'hFF));
        ph_q.push_back({2'b01, 8'hFF});
        rd_q.push_back(8'hA5);
        @(negedge CLK);
        LD_CHIP  = 1'b0;
        LD_REG   = 4'h8;
        LD_VAL   = 8'h0F;
        LD_VALID = 1'b1;
        @(negedge CLK);
        LD_VALID = 1'b0;
        CPU_RD   = 1'b1;
        PSG_DO   = 8'hA5;
        @(negedge CLK);
        CPU_RD = 1'b0;
        chk("rd_wait_set", CPU_WAIT, 1);
        wcnt = 0;
        for (int c = 0; c < 300 && CPU_WAIT; c++) begin
            wcnt++;
            @(negedge CLK);
        end
        chk("rd_wait_cycles", wcnt, 15);
        for (int c = 0; c < 300 && BUSY; c++) @(negedge CLK);
        repeat (4) @(negedge CLK);
        chk("rd_do_hold", CPU_DO, 8'hA5);
        chk("rd_do_valid_low", CPU_DO_VALID, 0);

        // Reset during L_DATA
        mon_en = 1'b0;
        @(negedge CLK);
        LD_CHIP  = 1'b0;
        LD_REG   = 4'h1;
        LD_VAL   = 8'h77;
        LD_VALID = 1'b1;
        @(negedge CLK);
        LD_VALID = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (PSG_BDIR && !PSG_BC) begin
                hit = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!hit) fail("reach_l_data");
        RESET_N = 1'b0;
        @(negedge CLK);
        chk("mid_rst_bdir", PSG_BDIR, 0);
        chk("mid_rst_bc", PSG_BC, 0);
        chk("mid_rst_busy", BUSY, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("mid_rel_ld_ready", LD_READY, 1);
        chk("mid_rel_cpu_sel", CPU_SEL, 1);
        chk("mid_rel_wait", CPU_WAIT, 0);
        ph_q.delete();
        rd_q.delete();
        mon_en = 1'b1;

        // Shadow addresses cleared: restores drive 0x00
`ifdef PSG_SEQ_SHADOW_EN
        run_vec(mk(1, 0, 0, 1, 4'h5, 8'hAA, 3, pw(1, 8'h05), pw(0, 8'hAA),
                   pw(1, 8'h00), 0, 0, 1), "post_rst_c1");
`else
        run_vec(mk(1, 0, 0, 1, 4'h5, 8'hAA, 5, pw(1, 8'hFF), pw(1, 8'h05),
                   pw(0, 8'hAA), pw(1, 8'h00), pw(1, 8'hFF), 1), "post_rst_c1");
`endif
        run_vec(mk(1, 0, 0, 0, 4'h8, 8'h0F, 5, pw(1, 8'hFE), pw(1, 8'h08),
                   pw(0, 8'h0F), pw(1, 8'h00), pw(1, 8'hFF), 1), "post_rst_c0");

        repeat (3) @(negedge CLK);
        chk("ph_q_empty", ph_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
